// File: rtl/csa_operand_sequencer.sv
// ---------------------------------------------------------------------------
// csa_operand_sequencer
//
// Feeds a registered carry-select adder and collects its result.
// - Builds operand A and then operand B from a narrow valid/ready word
//   stream. Words arrive least-significant first.
// - Holds both operands stable on the adder inputs.
// - Waits out the adder's fixed latency, then captures sum and carry-out.
// - Presents the captured result with a valid/ack handshake.
//
// Parameters
//   WIDTH    operand / sum width; must match the adder instance
//   BUS_W    input word width; WIDTH must be a multiple of BUS_W
//   ADD_LAT  adder latency in clock edges (>= 1)
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   asynchronous, active-low reset
//   in_valid   in   in_data holds a valid word
//   in_ready   out  a word is accepted this cycle (LOAD_A / LOAD_B only)
//   in_data    in   operand word: all of A first, then all of B
//   op_a       out  operand A to the adder
//   op_b       out  operand B to the adder
//   sum_in     in   adder sum output
//   cout_in    in   adder carry-out
//   res_valid  out  res_sum / res_cout hold a valid result
//   res_ack    in   consumer takes the result
//   res_sum    out  captured sum
//   res_cout   out  captured carry-out
// ---------------------------------------------------------------------------
module csa_operand_sequencer #(
  parameter int WIDTH   = 1024,
  parameter int BUS_W   = 32,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout
);

  localparam int NW    = WIDTH / BUS_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  // The wait counter only has to hold ADD_LAT-1.
  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NW - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] widx;
  logic [CNT_W-1:0] wait_cnt;

  // Ready is a pure decode of the registered state.
  // There is deliberately no path from in_valid to in_ready.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      widx      <= '0;
      wait_cnt  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: begin
          if (in_valid) begin
            // Word-slot decode avoids a variable-width multiply in the index.
            for (int i = 0; i < NW; i++) begin
              if (widx == IDX_W'(i)) begin
                op_a[i*BUS_W +: BUS_W] <= in_data;
              end
            end
            if (widx == LAST_IDX) begin
              widx  <= '0;
              state <= LOAD_B;
            end else begin
              widx <= widx + IDX_W'(1);
            end
          end
        end

        LOAD_B: begin
          if (in_valid) begin
            for (int i = 0; i < NW; i++) begin
              if (widx == IDX_W'(i)) begin
                op_b[i*BUS_W +: BUS_W] <= in_data;
              end
            end
            if (widx == LAST_IDX) begin
              widx     <= '0;
              wait_cnt <= WAIT_INIT;
              state    <= WAIT;
            end else begin
              widx <= widx + IDX_W'(1);
            end
          end
        end

        // Operands are now frozen.
        // Capture on the ADD_LAT-th edge after the last B word was written.
        WAIT: begin
          if (wait_cnt == '0) begin
            res_sum   <= sum_in;
            res_cout  <= cout_in;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        // The result stays on res_sum/res_cout after the ack.
        // It is overwritten only by the next capture.
        HOLD: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end

        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csa_operand_sequencer
//
// Directed bench for csa_operand_sequencer with WIDTH=64, BUS_W=16, ADD_LAT=2.
// - A behavioural adder stands in for the CSA.
// - The adder registers a+b once per edge. Its output therefore reflects the
//   final operands one edge after the last B word is written. The sequencer
//   samples it on the second edge.
// ---------------------------------------------------------------------------
module tb_csa_operand_sequencer;

  localparam int WIDTH   = 64;
  localparam int BUS_W   = 16;
  localparam int ADD_LAT = 2;
  localparam int NW      = WIDTH / BUS_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BUS_W-1:0] in_data = '0;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] adder_sum = '0;
  logic             adder_cout = 1'b0;
  logic             res_valid;
  logic             res_ack = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;

  csa_operand_sequencer #(
    .WIDTH  (WIDTH),
    .BUS_W  (BUS_W),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .op_a     (op_a),
    .op_b     (op_b),
    .sum_in   (adder_sum),
    .cout_in  (adder_cout),
    .res_valid(res_valid),
    .res_ack  (res_ack),
    .res_sum  (res_sum),
    .res_cout (res_cout)
  );

  always #5 clk = ~clk;

  // Stand-in for the registered adder.
  always @(posedge clk) begin
    {adder_cout, adder_sum} <= {1'b0, op_a} + {1'b0, op_b};
  end

  // Count every word handed over on the input handshake.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [WIDTH:0] obs,
                             input logic [WIDTH:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and keep it there until the handshake completes.
  task automatic sendWord(input logic [BUS_W-1:0] w);
    int budget;
    bit done;
    budget = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    while (!done && budget < 50) begin
      done = in_ready;
      tick();
      budget++;
    end
    if (!done) checkOutput("send_timeout", 65'd0, 65'd1);
  endtask

  // Stream A then B, least-significant word first.
  // With gaps set, an idle cycle carrying garbage precedes each word.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit gaps);
    logic [2*WIDTH-1:0] both;
    both = {b, a};
    for (int i = 0; i < 2*NW; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data = BUS_W'($urandom);
        tick();
      end
      sendWord(both[i*BUS_W +: BUS_W]);
    end
    in_valid = 1'b0;
    in_data = BUS_W'($urandom);
  endtask

  task automatic waitResult(input string tag);
    int budget;
    budget = 0;
    while (!res_valid && budget < 20) begin
      tick();
      budget++;
    end
    if (!res_valid) checkOutput({tag, "_valid_timeout"}, 65'd0, 65'd1);
  endtask

  task automatic ackResult(input int delay, input logic [WIDTH:0] exp, input string tag);
    repeat (delay) tick();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    checkOutput({tag, "_valid_after_ack"}, {64'd0, res_valid}, 65'd0);
    checkOutput({tag, "_ready_after_ack"}, {64'd0, in_ready}, 65'd1);
    checkOutput({tag, "_result_kept"}, {res_cout, res_sum}, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] save_a;
    logic [WIDTH-1:0] save_b;
    logic [WIDTH-1:0] save_s;
    int               acc0;

    // Reset state.
    #12;
    checkOutput("rst_op_a", {1'b0, op_a}, 65'd0);
    checkOutput("rst_op_b", {1'b0, op_b}, 65'd0);
    checkOutput("rst_res", {res_cout, res_sum}, 65'd0);
    checkOutput("rst_valid", {64'd0, res_valid}, 65'd0);
    checkOutput("rst_ready", {64'd0, in_ready}, 65'd1);
    rst_n = 1'b1;
    tick();

    // 1: 1 + 2 with continuous valid; result exactly two edges after the last B accept.
    applyStimulus(64'd1, 64'd2, 1'b0);
    checkOutput("t1_valid_T", {64'd0, res_valid}, 65'd0);
    checkOutput("t1_ready_wait", {64'd0, in_ready}, 65'd0);
    tick();
    checkOutput("t1_valid_T1", {64'd0, res_valid}, 65'd0);
    tick();
    checkOutput("t1_valid_T2", {64'd0, res_valid}, 65'd1);
    checkOutput("t1_sum", {res_cout, res_sum}, 65'd3);
    checkOutput("t1_op_a", {1'b0, op_a}, 65'd1);
    checkOutput("t1_op_b", {1'b0, op_b}, 65'd2);
    ackResult(1, 65'd3, "t1");

    // 2: all ones + all ones -> carry-out set.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    waitResult("t2");
    checkOutput("t2_sum", {res_cout, res_sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    ackResult(0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}, "t2");

    // 3: in_valid toggling; only valid words may be consumed.
    acc0 = acc_cnt;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'd1, 1'b1);
    checkOutput("t3_accepts", 65'(acc_cnt - acc0), 65'd8);
    checkOutput("t3_op_a", {1'b0, op_a}, {1'b0, 64'h1234_5678_9ABC_DEF0});
    waitResult("t3");
    checkOutput("t3_sum", {res_cout, res_sum}, {1'b0, 64'h1234_5678_9ABC_DEF1});

    // 4: result withheld for 10 cycles with in_valid high; nothing moves.
    save_a = op_a;
    save_b = op_b;
    save_s = res_sum;
    acc0 = acc_cnt;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t4_ready_low", {64'd0, in_ready}, 65'd0);
    end
    checkOutput("t4_no_accepts", 65'(acc_cnt - acc0), 65'd0);
    checkOutput("t4_op_a_stable", {1'b0, op_a}, {1'b0, save_a});
    checkOutput("t4_op_b_stable", {1'b0, op_b}, {1'b0, save_b});
    checkOutput("t4_sum_stable", {1'b0, res_sum}, {1'b0, save_s});
    checkOutput("t4_valid_held", {64'd0, res_valid}, 65'd1);
    in_valid = 1'b0;
    ackResult(0, {1'b0, 64'h1234_5678_9ABC_DEF1}, "t4");

    // 5: reset after three B words discards the operation.
    for (int i = 0; i < NW; i++) sendWord(16'h0005 + BUS_W'(i));
    for (int i = 0; i < 3; i++) sendWord(16'h0100);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_op_a", {1'b0, op_a}, 65'd0);
    checkOutput("t5_op_b", {1'b0, op_b}, 65'd0);
    checkOutput("t5_res", {res_cout, res_sum}, 65'd0);
    checkOutput("t5_valid", {64'd0, res_valid}, 65'd0);
    checkOutput("t5_ready", {64'd0, in_ready}, 65'd1);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(64'h0000_0000_0001_0010, 64'h0000_0000_0002_0020, 1'b0);
    waitResult("t5");
    checkOutput("t5_sum", {res_cout, res_sum}, 65'h0_0000_0000_0003_0030);
    ackResult(2, 65'h0_0000_0000_0003_0030, "t5");

    // 6: three back-to-back random operations with random ack delays.
    for (int k = 0; k < 3; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      exp = {1'b0, a} + {1'b0, b};
      applyStimulus(a, b, 1'b0);
      waitResult("t6");
      checkOutput("t6_sum", {res_cout, res_sum}, exp);
      ackResult(int'($urandom_range(0, 3)), exp, "t6");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
